// File: rtl/plot_sink.sv
// plot_sink: receiving end of the snake pixel-plot interface.
// Plot commands are range-checked, converted to a linear framebuffer address
// (y*WIDTH + x) and queued in a small FIFO. A single output register then
// issues one pixel write per cycle under fb_ready backpressure. A clear
// sequencer can take over the write port and fill the whole screen with one
// colour.
module plot_sink #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              plot_en,
    input  logic [7:0]        x,
    input  logic [6:0]        y,
    input  logic [2:0]        colour_in,
    input  logic              clear_req,
    input  logic [2:0]        clear_colour,
    input  logic              fb_ready,
    output logic              fb_wren,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              busy,
    output logic              clear_done,
    output logic              overflow
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = ADDR_W + 3;

    localparam logic [PTR_W:0]      FULL_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]      ZERO_CNT  = {(PTR_W + 1){1'b0}};
    localparam logic [8:0]          X_LIM     = 9'(WIDTH);
    localparam logic [7:0]          Y_LIM     = 8'(HEIGHT);
    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_CLEAR_WAIT = 2'd1,
        ST_CLEAR      = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;

    logic [ENTRY_W-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W:0]      count_r;

    logic                fb_wren_r;
    logic [ADDR_W-1:0]   fb_addr_r;
    logic [2:0]          fb_data_r;
    logic                busy_r;
    logic                clear_done_r;
    logic                overflow_r;
    logic [ADDR_W-1:0]   clr_cnt_r;
    logic [2:0]          clr_colour_r;

    logic                in_range_s;
    logic [ADDR_W-1:0]   plot_addr_s;
    logic [ENTRY_W-1:0]  head_s;
    logic                write_done_s;
    logic                push_s;
    logic                pop_s;
    logic                flush_s;
    logic                ovf_next_s;
    logic [ADDR_W-1:0]   clr_cnt_next_s;
    logic [2:0]          clr_colour_next_s;
    logic                wren_next_s;
    logic [ADDR_W-1:0]   addr_next_s;
    logic [2:0]          data_next_s;
    logic                done_next_s;
    logic                busy_next_s;

    assign in_range_s   = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    assign plot_addr_s  = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    assign head_s       = mem_r[rd_ptr_r];
    assign write_done_s = fb_wren_r & fb_ready;

    assign fb_wren    = fb_wren_r;
    assign fb_addr    = fb_addr_r;
    assign fb_data    = fb_data_r;
    assign busy       = busy_r;
    assign clear_done = clear_done_r;
    assign overflow   = overflow_r;

    // Next-state, FIFO push/pop decisions and next output-register values
    always_comb begin
        next_state_s      = state_r;
        push_s            = 1'b0;
        pop_s             = 1'b0;
        flush_s           = 1'b0;
        ovf_next_s        = overflow_r;
        clr_cnt_next_s    = clr_cnt_r;
        clr_colour_next_s = clr_colour_r;
        wren_next_s       = fb_wren_r;
        addr_next_s       = fb_addr_r;
        data_next_s       = fb_data_r;
        done_next_s       = 1'b0;
        case (state_r)
            ST_RUN: begin
                // Output register reloads whenever it is empty or draining.
                if ((count_r != ZERO_CNT) && (!fb_wren_r || fb_ready)) begin
                    pop_s       = 1'b1;
                    wren_next_s = 1'b1;
                    addr_next_s = head_s[ADDR_W-1:0];
                    data_next_s = head_s[ENTRY_W-1 -: 3];
                end else if (write_done_s) begin
                    wren_next_s = 1'b0;
                end else begin
                    wren_next_s = fb_wren_r;
                end
                // A clear request takes priority over a same-cycle plot.
                if (clear_req) begin
                    next_state_s      = ST_CLEAR_WAIT;
                    clr_colour_next_s = clear_colour;
                end else if (plot_en && in_range_s) begin
                    if ((count_r != FULL_CNT) || pop_s) begin
                        push_s = 1'b1;
                    end else begin
                        ovf_next_s = 1'b1;
                    end
                end else begin
                    push_s = 1'b0;
                end
            end
            ST_CLEAR_WAIT: begin
                // Let the in-flight write finish, then drop everything queued.
                if (!fb_wren_r || fb_ready) begin
                    flush_s        = 1'b1;
                    ovf_next_s     = 1'b0;
                    clr_cnt_next_s = {ADDR_W{1'b0}};
                    next_state_s   = ST_CLEAR;
                    wren_next_s    = 1'b1;
                    addr_next_s    = {ADDR_W{1'b0}};
                    data_next_s    = clr_colour_r;
                end else begin
                    next_state_s = ST_CLEAR_WAIT;
                end
            end
            ST_CLEAR: begin
                if (write_done_s) begin
                    if (clr_cnt_r == LAST_ADDR) begin
                        next_state_s = ST_RUN;
                        wren_next_s  = 1'b0;
                        done_next_s  = 1'b1;
                    end else begin
                        clr_cnt_next_s = clr_cnt_r + ADDR_W'(1);
                        addr_next_s    = clr_cnt_r + ADDR_W'(1);
                    end
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            default: begin
                next_state_s = ST_RUN;
                wren_next_s  = 1'b0;
            end
        endcase
        busy_next_s = (next_state_s != ST_RUN);
    end

    // State, output register and clear sequencer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_RUN;
            fb_wren_r    <= 1'b0;
            fb_addr_r    <= {ADDR_W{1'b0}};
            fb_data_r    <= 3'd0;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b0;
            overflow_r   <= 1'b0;
            clr_cnt_r    <= {ADDR_W{1'b0}};
            clr_colour_r <= 3'd0;
        end else begin
            state_r      <= next_state_s;
            fb_wren_r    <= wren_next_s;
            fb_addr_r    <= addr_next_s;
            fb_data_r    <= data_next_s;
            busy_r       <= busy_next_s;
            clear_done_r <= done_next_s;
            overflow_r   <= ovf_next_s;
            clr_cnt_r    <= clr_cnt_next_s;
            clr_colour_r <= clr_colour_next_s;
        end
    end

    // FIFO pointers and occupancy; a flush empties the queue in one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_CNT;
        end else if (flush_s) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= ZERO_CNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: {colour, addr} written at the tail on push
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {colour_in, plot_addr_s};
        end
    end

endmodule

// File: tb/tb_plot_sink.sv
// Directed bench for plot_sink. Inputs change 2 ns after each rising edge;
// accepted writes (fb_wren & fb_ready) are logged on the falling edge, i.e.
// just before the rising edge that completes them.
module tb_plot_sink;

    logic        clk;
    logic        rst;
    logic        plot_en;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour_in;
    logic        clear_req;
    logic [2:0]  clear_colour;
    logic        fb_ready;
    logic        fb_wren;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        busy;
    logic        clear_done;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int log_addr[$];
    int log_data[$];

    plot_sink #(.DEPTH(16), .WIDTH(160), .HEIGHT(120), .ADDR_W(15)) dut (
        .clk(clk), .rst(rst), .plot_en(plot_en), .x(x), .y(y),
        .colour_in(colour_in), .clear_req(clear_req), .clear_colour(clear_colour),
        .fb_ready(fb_ready), .fb_wren(fb_wren), .fb_addr(fb_addr), .fb_data(fb_data),
        .busy(busy), .clear_done(clear_done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fb_wren && fb_ready) begin
            log_addr.push_back(int'(fb_addr));
            log_data.push_back(int'(fb_data));
        end
        if (clear_done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; plot_en = 1'b0; x = 8'd0; y = 7'd0; colour_in = 3'd0;
        clear_req = 1'b0; clear_colour = 3'd0; fb_ready = 1'b1;
        step(); step();
        checks++;
        if ({fb_wren, fb_addr, fb_data, busy, clear_done, overflow} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: wren=%0b addr=%0d data=%0d busy=%0b done=%0b ovf=%0b, expected all 0",
                     fb_wren, fb_addr, fb_data, busy, clear_done, overflow);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        clear_log();
        fb_ready = 1'b1;
        plot_en = 1'b1; x = 8'd3; y = 7'd2; colour_in = 3'd5;
        step();
        plot_en = 1'b0;
        checks++;
        if (fb_wren !== 1'b0) begin
            errors++; $display("FAIL single_early: fb_wren=%0b expected 0", fb_wren);
        end
        step();
        checks++;
        if (fb_wren !== 1'b1 || fb_addr !== 15'd323 || fb_data !== 3'd5) begin
            errors++;
            $display("FAIL single_write: wren=%0b addr=%0d data=%0d expected 1/323/5", fb_wren, fb_addr, fb_data);
        end
        step();
        checks++;
        if (fb_wren !== 1'b0) begin
            errors++; $display("FAIL single_pulse: fb_wren=%0b expected 0", fb_wren);
        end
        step(); step();
        checks++;
        if (log_addr.size() != 1) begin
            errors++; $display("FAIL single_count: writes=%0d expected 1", log_addr.size());
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        fb_ready = 1'b0;
        plot_en = 1'b1; x = 8'd159; y = 7'd119; colour_in = 3'd7;
        step();
        plot_en = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            fb_ready = (c == 2);
            checks++;
            if (fb_wren !== 1'b1 || fb_addr !== 15'd19199 || fb_data !== 3'd7) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: wren=%0b addr=%0d data=%0d expected 1/19199/7",
                         c, fb_wren, fb_addr, fb_data);
            end
            step();
        end
        fb_ready = 1'b1;
        checks++;
        if (fb_wren !== 1'b0) begin
            errors++; $display("FAIL bp_release: fb_wren=%0b expected 0", fb_wren);
        end
        step(); step();
        checks++;
        if (log_addr.size() != 1 || log_addr[0] != 19199) begin
            errors++; $display("FAIL bp_accepted: writes=%0d expected exactly one at 19199", log_addr.size());
        end
    endtask

    task automatic test_out_of_range();
        clear_log();
        fb_ready = 1'b1;
        plot_en = 1'b1; x = 8'd160; y = 7'd0; colour_in = 3'd2;
        step();
        x = 8'd0; y = 7'd120;
        step();
        plot_en = 1'b0;
        step(); step(); step();
        checks++;
        if (log_addr.size() != 0 || fb_wren !== 1'b0) begin
            errors++; $display("FAIL oor_write: writes=%0d wren=%0b expected 0/0", log_addr.size(), fb_wren);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL oor_overflow: overflow=%0b expected 0", overflow);
        end
    endtask

    // 20 plots with fb_ready low: the first plot moves into the output register
    // on the edge after it is queued, so 16 FIFO slots + 1 register = 17 kept, 3 dropped.
    task automatic test_burst();
        int n;
        int bad;
        clear_log();
        fb_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            plot_en = 1'b1; x = 8'(i * 7); y = 7'(i * 5); colour_in = 3'(i);
            step();
        end
        plot_en = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL burst_overflow: overflow=%0b expected 1", overflow);
        end
        fb_ready = 1'b1;
        n = 0;
        while (log_addr.size() < 17 && n < 100) begin
            step(); n++;
        end
        step(); step(); step();
        checks++;
        if (log_addr.size() != 17) begin
            errors++; $display("FAIL burst_count: writes=%0d expected 17", log_addr.size());
        end
        bad = 0;
        for (int i = 0; i < 17 && i < log_addr.size(); i++) begin
            if (log_addr[i] != (i * 5) * 160 + i * 7 || log_data[i] != (i % 8)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL burst_order: %0d entries wrong, expected 0", bad);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL burst_sticky: overflow=%0b expected 1", overflow);
        end
    endtask

    task automatic test_clear();
        int n;
        int bad;
        int busy_bad;
        int done0;
        clear_log();
        done0 = done_cnt;
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            plot_en = 1'b1; x = 8'(10 + i); y = 7'd10; colour_in = 3'(2 + i);
            step();
        end
        // clear_req together with a plot: clear wins, plot discarded
        clear_req = 1'b1; clear_colour = 3'd1; x = 8'd50; y = 7'd50; colour_in = 3'd6;
        step();
        clear_req = 1'b0; clear_colour = 3'd6;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL clear_busy_start: busy=%0b expected 1", busy);
        end
        fb_ready = 1'b1;
        n = 0; busy_bad = 0;
        while (clear_done !== 1'b1 && n < 25000) begin
            if (busy !== 1'b1) busy_bad++;
            plot_en = (n < 50);
            x = 8'(n % 160); y = 7'(n % 120);
            clear_req = (n == 100);
            clear_colour = 3'd3;
            step(); n++;
        end
        plot_en = 1'b0; clear_req = 1'b0;
        checks++;
        if (clear_done !== 1'b1) begin
            errors++; $display("FAIL clear_timeout: clear_done never seen after %0d cycles", n);
        end
        checks++;
        if (busy_bad != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL clear_busy: low %0d times during clear, busy at done=%0b expected 0/0", busy_bad, busy);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL clear_overflow: overflow=%0b expected 0", overflow);
        end
        step();
        checks++;
        if (clear_done !== 1'b0 || fb_wren !== 1'b0) begin
            errors++; $display("FAIL clear_done_pulse: done=%0b wren=%0b expected 0/0", clear_done, fb_wren);
        end
        step(); step();
        // The in-flight write (10,10) completes first; the two queued behind it are flushed.
        checks++;
        if (log_addr.size() != 19201) begin
            errors++; $display("FAIL clear_count: writes=%0d expected 19201", log_addr.size());
        end
        checks++;
        if (log_addr.size() < 1 || log_addr[0] != 1610 || log_data[0] != 2) begin
            errors++; $display("FAIL clear_inflight: first write wrong, expected addr 1610 data 2");
        end
        bad = 0;
        for (int k = 0; k < 19200 && k + 1 < log_addr.size(); k++) begin
            if (log_addr[k + 1] != k || log_data[k + 1] != 1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL clear_sequence: %0d writes wrong, expected 0", bad);
        end
        checks++;
        if (done_cnt - done0 != 1) begin
            errors++; $display("FAIL clear_done_count: pulses=%0d expected 1", done_cnt - done0);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int done0;
        fb_ready = 1'b1;
        clear_req = 1'b1; clear_colour = 3'd2;
        step();
        clear_req = 1'b0;
        n = 0;
        while (!(fb_wren === 1'b1 && fb_addr === 15'd5000) && n < 6000) begin
            step(); n++;
        end
        checks++;
        if (fb_addr !== 15'd5000) begin
            errors++; $display("FAIL midclr_reach: addr=%0d expected 5000", fb_addr);
        end
        done0 = done_cnt;
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({fb_wren, fb_addr, fb_data, busy, clear_done, overflow} !== 23'd0) begin
            errors++;
            $display("FAIL midclr_async: wren=%0b addr=%0d data=%0d busy=%0b done=%0b ovf=%0b expected all 0",
                     fb_wren, fb_addr, fb_data, busy, clear_done, overflow);
        end
        step(); step();
        rst = 1'b1;
        step();
        clear_log();
        plot_en = 1'b1; x = 8'd0; y = 7'd0; colour_in = 3'd3;
        step();
        plot_en = 1'b0;
        step(); step(); step();
        checks++;
        if (log_addr.size() != 1 || log_addr[0] != 0 || log_data[0] != 3) begin
            errors++; $display("FAIL midclr_plot: writes=%0d expected one at addr 0 data 3", log_addr.size());
        end
        checks++;
        if (done_cnt != done0 || busy !== 1'b0) begin
            errors++; $display("FAIL midclr_nodone: pulses=%0d busy=%0b expected 0/0", done_cnt - done0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_out_of_range();
        test_burst();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
